rs_scheduler: RTL and testbench

//  Controls a bank of NUM_ENTRIES reservation-station entries (RS_entry) between decode and one FU.

---
 rtl/rs_scheduler_if.sv | 41 ++++
 rtl/rs_scheduler.sv | 136 +++++++++++++
 tb/tb_rs_scheduler.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/rs_scheduler_if.sv
// ---------------------------------------------------------------------------
// rs_scheduler_if : decode/RS/FU-side signal bundle of the RS scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rs_scheduler_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int STALL_W     = 16
) ();

  // i_/o_ are named from the scheduler's point of view
  logic [NUM_ENTRIES-1:0] i_entry_busy;
  logic [NUM_ENTRIES-1:0] i_entry_ready;
  logic                   i_dispatch_valid;
  logic                   o_dispatch_ready;
  logic [NUM_ENTRIES-1:0] o_entry_wr_en;
  logic                   o_issue_valid;
  logic [IDX_W-1:0]       o_issue_idx;
  logic                   i_issue_ack;
  logic [NUM_ENTRIES-1:0] o_entry_clear;
  logic                   i_squash;
  logic [IDX_W:0]         o_free_count;
  logic [STALL_W-1:0]     o_stall_cycles;

  modport slave (
    input  i_entry_busy, i_entry_ready, i_dispatch_valid, i_issue_ack, i_squash,
    output o_dispatch_ready, o_entry_wr_en, o_issue_valid, o_issue_idx,
           o_entry_clear, o_free_count, o_stall_cycles
  );

  modport master (
    output i_entry_busy, i_entry_ready, i_dispatch_valid, i_issue_ack, i_squash,
    input  o_dispatch_ready, o_entry_wr_en, o_issue_valid, o_issue_idx,
           o_entry_clear, o_free_count, o_stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/rs_scheduler.sv
// ---------------------------------------------------------------------------
// rs_scheduler : allocates RS entries, round-robin issue slot, clear + stall count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rs_scheduler #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int STALL_W     = 16
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  rs_scheduler_if.slave  bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_issue_idx;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [STALL_W-1:0]     r_stall_cycles;

  logic [NUM_ENTRIES-1:0] w_free;
  logic                   w_dispatch_ready;
  logic [NUM_ENTRIES-1:0] w_alloc_oh;
  logic                   w_alloc_found;
  logic [IDX_W:0]         w_free_count;
  logic                   w_issue_valid;
  logic [NUM_ENTRIES-1:0] w_issue_oh;
  logic [NUM_ENTRIES-1:0] w_cand;
  logic [IDX_W-1:0]       w_rr_idx;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_pick_vld;
  logic                   w_stall;
  logic                   w_slot_open;

  assign w_free           = ~bus.i_entry_busy;
  assign w_dispatch_ready = (|w_free) && !bus.i_squash;
  assign w_issue_valid    = (r_state == S_HELD);

  // Lowest-index free entry; a just-cleared entry still reads busy, so no same-cycle reuse
  always_comb begin
    w_alloc_oh    = '0;
    w_alloc_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (w_free[i] && !w_alloc_found) begin
        w_alloc_oh[i] = 1'b1;
        w_alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_free_count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_free_count = w_free_count + (IDX_W+1)'(w_free[i]);
    end
  end

  always_comb begin
    w_issue_oh = '0;
    if (w_issue_valid) begin
      w_issue_oh[r_issue_idx] = 1'b1;
    end
  end

  // The slot occupant is excluded so an acked entry is never re-picked before it clears
  assign w_cand = bus.i_entry_busy & bus.i_entry_ready & ~w_issue_oh;

  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_rr_idx   = r_rr_ptr;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_rr_idx = r_rr_ptr + IDX_W'(i);
      if (!w_pick_vld && w_cand[w_rr_idx]) begin
        w_pick     = w_rr_idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_stall     = bus.i_dispatch_valid && !w_dispatch_ready;
  assign w_slot_open = (r_state == S_EMPTY) || bus.i_issue_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_EMPTY;
      r_issue_idx    <= '0;
      r_rr_ptr       <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != {STALL_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + STALL_W'(1);
      end

      // Squash wins over a simultaneous ack and suppresses the pick
      if (bus.i_squash) begin
        r_state  <= S_EMPTY;
        r_rr_ptr <= '0;
      end else if (w_slot_open) begin
        if (w_pick_vld) begin
          r_state     <= S_HELD;
          r_issue_idx <= w_pick;
          r_rr_ptr    <= w_pick + IDX_W'(1);
        end else begin
          r_state     <= S_EMPTY;
        end
      end
    end
  end

  always_comb begin
    if (bus.i_squash) begin
      bus.o_entry_clear = '1;
    end else if (w_issue_valid && bus.i_issue_ack) begin
      bus.o_entry_clear = w_issue_oh;
    end else begin
      bus.o_entry_clear = '0;
    end
  end

  assign bus.o_dispatch_ready = w_dispatch_ready;
  assign bus.o_entry_wr_en    = (bus.i_dispatch_valid && w_dispatch_ready) ? w_alloc_oh : '0;
  assign bus.o_issue_valid    = w_issue_valid;
  assign bus.o_issue_idx      = r_issue_idx;
  assign bus.o_free_count     = w_free_count;
  assign bus.o_stall_cycles   = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_rs_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rs_scheduler : directed self-checking bench for rs_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rs_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  rs_scheduler_if #(.NUM_ENTRIES(8), .IDX_W(3), .STALL_W(16)) bus ();

  rs_scheduler #(.NUM_ENTRIES(8), .IDX_W(3), .STALL_W(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; registered outputs are read there too
  task automatic do_reset();
    bus.i_entry_busy     = 8'h00;
    bus.i_entry_ready    = 8'h00;
    bus.i_dispatch_valid = 1'b0;
    bus.i_issue_ack      = 1'b0;
    bus.i_squash         = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus.i_dispatch_valid = 1'b1;
    #1;
    n_checks++; if (bus.o_entry_wr_en !== 8'h01) begin n_fail++; $display("FAIL reset_wr_en got=%h exp=01", bus.o_entry_wr_en); end
    n_checks++; if (bus.o_dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_dready got=%b exp=1", bus.o_dispatch_ready); end
    n_checks++; if (bus.o_free_count !== 4'd8) begin n_fail++; $display("FAIL reset_free got=%0d exp=8", bus.o_free_count); end
    n_checks++; if (bus.o_issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ivalid got=%b exp=0", bus.o_issue_valid); end
    n_checks++; if (bus.o_issue_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", bus.o_issue_idx); end
    n_checks++; if (bus.o_stall_cycles !== 16'd0) begin n_fail++; $display("FAIL reset_stall got=%0d exp=0", bus.o_stall_cycles); end
  endtask

  task automatic test_dispatch();
    logic [7:0] busy_v [4] = '{8'h0A, 8'h07, 8'h7F, 8'hFE};
    logic [7:0] wr_v   [4] = '{8'h01, 8'h08, 8'h80, 8'h01};
    logic [3:0] free_v [4] = '{4'd6,  4'd5,  4'd1,  4'd1};
    do_reset();
    bus.i_dispatch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.i_entry_busy = busy_v[i];
      #1;
      n_checks++; if (bus.o_entry_wr_en !== wr_v[i]) begin n_fail++; $display("FAIL disp_wr_en[%0d] got=%h exp=%h", i, bus.o_entry_wr_en, wr_v[i]); end
      n_checks++; if (bus.o_free_count !== free_v[i]) begin n_fail++; $display("FAIL disp_free[%0d] got=%0d exp=%0d", i, bus.o_free_count, free_v[i]); end
      @(negedge clk);
    end
    bus.i_dispatch_valid = 1'b0;
    bus.i_entry_busy     = 8'h0A;
    #1;
    n_checks++; if (bus.o_entry_wr_en !== 8'h00) begin n_fail++; $display("FAIL disp_novalid got=%h exp=00", bus.o_entry_wr_en); end
    n_checks++; if (bus.o_stall_cycles !== 16'd0) begin n_fail++; $display("FAIL disp_nostall got=%0d exp=0", bus.o_stall_cycles); end
  endtask

  task automatic test_full_stall();
    do_reset();
    bus.i_entry_busy     = 8'hFF;
    bus.i_dispatch_valid = 1'b1;
    #1;
    n_checks++; if (bus.o_entry_wr_en !== 8'h00) begin n_fail++; $display("FAIL full_wr_en got=%h exp=00", bus.o_entry_wr_en); end
    n_checks++; if (bus.o_dispatch_ready !== 1'b0) begin n_fail++; $display("FAIL full_dready got=%b exp=0", bus.o_dispatch_ready); end
    n_checks++; if (bus.o_free_count !== 4'd0) begin n_fail++; $display("FAIL full_free got=%0d exp=0", bus.o_free_count); end
    repeat (3) @(negedge clk);
    bus.i_dispatch_valid = 1'b0;
    #1;
    n_checks++; if (bus.o_stall_cycles !== 16'd3) begin n_fail++; $display("FAIL stall3 got=%0d exp=3", bus.o_stall_cycles); end
    @(negedge clk);
    n_checks++; if (bus.o_stall_cycles !== 16'd3) begin n_fail++; $display("FAIL stall_hold got=%0d exp=3", bus.o_stall_cycles); end
    n_checks++; if (bus.o_issue_valid !== 1'b0) begin n_fail++; $display("FAIL full_noissue got=%b exp=0", bus.o_issue_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq [4] = '{3'd1, 3'd3, 3'd1, 3'd3};
    logic [7:0] exp_clr;
    do_reset();
    bus.i_entry_busy  = 8'h0A;
    bus.i_entry_ready = 8'h0A;
    bus.i_issue_ack   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_clr = (seq[i] == 3'd1) ? 8'h02 : 8'h08;
      n_checks++; if (bus.o_issue_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got=%b exp=1", i, bus.o_issue_valid); end
      n_checks++; if (bus.o_issue_idx !== seq[i]) begin n_fail++; $display("FAIL rr_idx[%0d] got=%0d exp=%0d", i, bus.o_issue_idx, seq[i]); end
      n_checks++; if (bus.o_entry_clear !== exp_clr) begin n_fail++; $display("FAIL rr_clear[%0d] got=%h exp=%h", i, bus.o_entry_clear, exp_clr); end
    end
    bus.i_issue_ack = 1'b0;
  endtask

  task automatic test_hold_and_squash();
    do_reset();
    bus.i_entry_busy  = 8'h28;
    bus.i_entry_ready = 8'h28;
    @(negedge clk);
    n_checks++; if (bus.o_issue_idx !== 3'd3) begin n_fail++; $display("FAIL hold_first got=%0d exp=3", bus.o_issue_idx); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (bus.o_issue_idx !== 3'd3 || bus.o_issue_valid !== 1'b1) begin n_fail++; $display("FAIL hold_idx[%0d] got=%0d/%b exp=3/1", i, bus.o_issue_idx, bus.o_issue_valid); end
      n_checks++; if (bus.o_entry_clear !== 8'h00) begin n_fail++; $display("FAIL hold_clear[%0d] got=%h exp=00", i, bus.o_entry_clear); end
    end
    bus.i_issue_ack = 1'b1;
    #1;
    n_checks++; if (bus.o_entry_clear !== 8'h08) begin n_fail++; $display("FAIL ack_clear got=%h exp=08", bus.o_entry_clear); end
    @(negedge clk);
    bus.i_issue_ack = 1'b0;
    n_checks++; if (bus.o_issue_idx !== 3'd5) begin n_fail++; $display("FAIL ack_next got=%0d exp=5", bus.o_issue_idx); end
    // Squash with ack and dispatch all asserted; rr pointer is now 6
    bus.i_issue_ack      = 1'b1;
    bus.i_dispatch_valid = 1'b1;
    bus.i_squash         = 1'b1;
    #1;
    n_checks++; if (bus.o_entry_clear !== 8'hFF) begin n_fail++; $display("FAIL sq_clear got=%h exp=FF", bus.o_entry_clear); end
    n_checks++; if (bus.o_entry_wr_en !== 8'h00) begin n_fail++; $display("FAIL sq_wr_en got=%h exp=00", bus.o_entry_wr_en); end
    n_checks++; if (bus.o_dispatch_ready !== 1'b0) begin n_fail++; $display("FAIL sq_dready got=%b exp=0", bus.o_dispatch_ready); end
    @(negedge clk);
    bus.i_squash         = 1'b0;
    bus.i_issue_ack      = 1'b0;
    bus.i_dispatch_valid = 1'b0;
    n_checks++; if (bus.o_issue_valid !== 1'b0) begin n_fail++; $display("FAIL sq_valid got=%b exp=0", bus.o_issue_valid); end
    n_checks++; if (bus.o_stall_cycles !== 16'd1) begin n_fail++; $display("FAIL sq_stall got=%0d exp=1", bus.o_stall_cycles); end
    bus.i_entry_busy  = 8'h81;
    bus.i_entry_ready = 8'h81;
    @(negedge clk);
    n_checks++; if (bus.o_issue_valid !== 1'b1 || bus.o_issue_idx !== 3'd0) begin n_fail++; $display("FAIL sq_restart got=%0d/%b exp=0/1", bus.o_issue_idx, bus.o_issue_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_entry_busy     = 8'hFF;
    bus.i_entry_ready    = 8'h01;
    bus.i_dispatch_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++; if (bus.o_stall_cycles !== 16'd5) begin n_fail++; $display("FAIL ar_pre_stall got=%0d exp=5", bus.o_stall_cycles); end
    n_checks++; if (bus.o_issue_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%b exp=1", bus.o_issue_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.o_issue_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", bus.o_issue_valid); end
    n_checks++; if (bus.o_stall_cycles !== 16'd0) begin n_fail++; $display("FAIL ar_stall got=%0d exp=0", bus.o_stall_cycles); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_dispatch_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    test_reset();
    test_dispatch();
    test_full_stall();
    test_round_robin();
    test_hold_and_squash();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
